// File: rtl/ram_fifo_arb.sv
// Round-robin write arbiter for two byte producers plus FIFO pointer/occupancy
// sequencing in front of an external single-write-port, async-read RAM.
module ram_fifo_arb #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] p0_data,
    input  logic                  p0_valid,
    output logic                  p0_ack,
    input  logic [DATA_WIDTH-1:0] p1_data,
    input  logic                  p1_valid,
    output logic                  p1_ack,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic [DATA_WIDTH-1:0] ram_in_data,
    output logic [DEPTH_LOG2-1:0] ram_in_addr,
    output logic                  ram_in_latch,
    output logic [DEPTH_LOG2-1:0] ram_out_addr,
    input  logic [DATA_WIDTH-1:0] ram_out_data
);

    localparam logic [DEPTH_LOG2:0]   DepthCount = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2-1:0] PtrOne     = (DEPTH_LOG2)'(1);
    localparam logic [DEPTH_LOG2:0]   CountOne   = (DEPTH_LOG2 + 1)'(1);

    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  last_q, last_d;

    logic full_int;
    logic can_grant;
    logic grant0;
    logic grant1;
    logic push;
    logic pop;

    // Arbitration only looks at registered state, so out_ready never reaches the acks.
    always_comb begin
        full_int  = (count_q == DepthCount);
        can_grant = !full_int && !reset && !flush;
        grant0    = can_grant && p0_valid && (!p1_valid || last_q);
        grant1    = can_grant && p1_valid && (!p0_valid || !last_q);
        push      = grant0 || grant1;
        pop       = out_valid && out_ready && !flush;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        last_d   = last_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PtrOne;
                last_d   = grant1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrOne;
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CountOne;
                2'b01:   count_d = count_q - CountOne;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            last_q   <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            last_q   <= last_d;
        end
    end

    // Status outputs are forced quiet while reset is high, before the clearing edge.
    always_comb begin
        p0_ack       = grant0;
        p1_ack       = grant1;
        ram_in_latch = push;
        ram_in_data  = grant1 ? p1_data : p0_data;
        ram_in_addr  = wr_ptr_q;
        ram_out_addr = rd_ptr_q;
        out_data     = ram_out_data;
        count        = reset ? '0 : count_q;
        out_valid    = !reset && (count_q != '0);
        full         = !reset && full_int;
    end

endmodule

// File: doc/ram_fifo_arb.md
# ram_fifo_arb

Round-robin write arbiter and FIFO sequencer for the dual-port RAM block (one write port, one asynchronous read port). Two byte producers share the single RAM write port. The block keeps circular write/read pointers and an occupancy count, so the RAM behaves as one FIFO for a single consumer. It sits between the ICE bus-side producers and the RAM instance; the RAM itself stays external.

## Interface
Parameters:
- DATA_WIDTH, 8, width of each FIFO entry; must match the RAM instance.
- DEPTH_LOG2, 4, log2 of the RAM depth; FIFO capacity DEPTH = 1 << DEPTH_LOG2 entries.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  synchronous clear of FIFO state; RAM contents untouched.
- p0_data  input  DATA_WIDTH  producer 0 entry.
- p0_valid  input  1  producer 0 requests a write.
- p0_ack  output  1  producer 0 entry written on this edge.
- p1_data  input  DATA_WIDTH  producer 1 entry.
- p1_valid  input  1  producer 1 requests a write.
- p1_ack  output  1  producer 1 entry written on this edge.
- out_data  output  DATA_WIDTH  head entry, i.e. ram_out_data passed through.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  consumer pops the head when out_valid is high.
- count  output  DEPTH_LOG2+1  current occupancy, 0..DEPTH.
- full  output  1  count == DEPTH.
- ram_in_data  output  DATA_WIDTH  to RAM write data.
- ram_in_addr  output  DEPTH_LOG2  to RAM write address, equal to wr_ptr.
- ram_in_latch  output  1  to RAM write enable.
- ram_out_addr  output  DEPTH_LOG2  to RAM read address, equal to rd_ptr.
- ram_out_data  input  DATA_WIDTH  from RAM asynchronous read data.

## Operation
- State registers:
  - wr_ptr, rd_ptr: DEPTH_LOG2 bits each, wrap modulo DEPTH.
  - count: DEPTH_LOG2+1 bits.
  - last: 1 bit, the most recently granted producer.
- Arbitration is combinational and uses the registered state:
  - Grant is allowed only if !full && !reset && !flush.
  - If exactly one producer is valid, that producer is granted.
  - If both are valid, grant goes to the producer that is not `last`.
  - If neither is valid, nothing is granted.
- On a grant in the current cycle:
  - pN_ack = 1 and ram_in_latch = 1.
  - ram_in_data = pN_data; ram_in_addr = wr_ptr.
  - On the edge: the RAM captures the entry, wr_ptr increments, and last = N.
- Without a grant: ram_in_latch = 0, both acks are 0, and ram_in_data = p0_data (don't-care for the RAM). `last` holds.
- A producer holds pN_valid and pN_data until it sees pN_ack. An ack consumes exactly one entry.
- Pop occurs when out_valid && out_ready && !flush.
  - On the edge, rd_ptr increments.
  - out_data is combinationally ram_out_data at address rd_ptr.
- Count update: count_next = count + push − pop. Simultaneous push and pop leaves count unchanged and advances both pointers.
- out_valid = (count != 0); full = (count == DEPTH).
- Boundary conditions:
  - **Full:** no grant, even if a pop occurs in the same cycle. Space freed by the pop becomes usable next cycle.
  - **Empty:** out_valid = 0 and out_ready is ignored. An entry written this cycle becomes visible next cycle, with no same-cycle bypass.
  - **Wrap:** when a pointer equals DEPTH−1, its increment yields 0.
  - **Flush:** wr_ptr, rd_ptr and count go to 0. `last` holds. In the flush cycle, acks and ram_in_latch are 0, and no pop occurs.
  - **Reset mid-operation:** all state is cleared as below. Any in-flight request is not acked; the producer re-presents it after reset.

## Timing
- Reset values, registered: wr_ptr = 0, rd_ptr = 0, count = 0, last = 1, so producer 0 wins the first contention.
- Outputs while reset is high: p0_ack = p1_ack = 0, ram_in_latch = 0, out_valid = 0, full = 0, count = 0.
- Ack has zero-cycle latency: it is asserted in the same cycle as ram_in_latch, and the write completes on that edge.
- Write-to-readable latency is 1 cycle: the entry is on out_data with out_valid = 1 in the cycle after its ack edge.
- Sustained throughput is one push and one pop per cycle. Under continuous contention, grants alternate p0, p1, p0, …
- No combinational path from out_ready to any ack or to ram_in_latch.

## Test plan
- **Reset then single producer:** p0 presents 0xA1, 0xA2, 0xA3 back to back.
  - p0_ack is high on 3 consecutive cycles; ram_in_addr is 0, 1, 2.
  - count reads 3, then out pops 0xA1, 0xA2, 0xA3 in order.
- **Contention:** p0 and p1 both valid continuously from reset, with data 0x10+i and 0x20+i.
  - Grants are p0, p1, p0, p1, …
  - FIFO order is 0x10, 0x20, 0x11, 0x21, …
- **Fill to full:** 16 pushes with no pops.
  - full = 1 and count = 16; the 17th request gets no ack.
  - Pop plus push in the same cycle: no ack in that cycle; the ack comes next cycle.
- **Wrap:** push 20 entries and pop 20 entries interleaved one push/one pop per cycle.
  - Pointers wrap 15→0, count stays ≤ 1, and data order is preserved.
- **Flush and reset mid-stream:** with count = 5 and p1 valid, assert flush for 1 cycle.
  - No ack in that cycle; count = 0 and out_valid = 0 the next cycle.
  - p1 is acked next cycle with ram_in_addr = 0.
  - Repeat with reset: same result, and p0 then wins the first contention.
